// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: complex sample, frame of POINT_FFT samples, bit reversal.
package fft_pkg;

    localparam int unsigned FFT_POW2      = 4;
    localparam int unsigned FFT_FRAC_BITS = 15;
    localparam int unsigned POINT_FFT     = 1 << FFT_POW2;

    // [0] = Re, [1] = Im, each signed Q1.FFT_FRAC_BITS
    typedef logic signed [1:0][FFT_FRAC_BITS:0] cplx_t;
    typedef cplx_t frame_t [POINT_FFT];

    // Reverse the low pow2 bits of idx; upper bits return zero.
    function automatic logic [15:0] bitrev(input logic [15:0] idx, input int unsigned pow2);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < pow2) begin
                r[i] = idx[4'(pow2 - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples: whole-frame write, single indexed combinational read.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned POW2      = FFT_POW2,
    parameter int unsigned FRAC_BITS = FFT_FRAC_BITS
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic signed [1:0][FRAC_BITS:0] wdata_i [1 << POW2],
    input  logic [POW2-1:0]               raddr_i,
    output logic signed [1:0][FRAC_BITS:0] rdata_c_o
);

    localparam int unsigned DEPTH = 1 << POW2;

    logic signed [1:0][FRAC_BITS:0] mem_q [DEPTH];
    logic signed [1:0][FRAC_BITS:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d = wdata_i;
        end
    end

    // Contents are deliberately left unreset; validity is tracked by the owner.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_streamer.sv
// Captures bit-reversed FFT frames into a ping-pong buffer and streams them out in
// natural bin order, one sample per cycle over valid/ready.
module fft_bitrev_streamer
    import fft_pkg::*;
#(
    parameter int unsigned POINT_FFT_POW2 = FFT_POW2,
    parameter int unsigned FRAC_BITS      = FFT_FRAC_BITS,
    parameter bit          BITREV_EN      = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic signed [1:0][FRAC_BITS:0] frame_i [1 << POINT_FFT_POW2],
    input  logic                           frame_valid_i,
    output logic                           frame_ready_o,
    output logic signed [1:0][FRAC_BITS:0] sample_o,
    output logic [POINT_FFT_POW2-1:0]      sample_idx_o,
    output logic                           sample_valid_o,
    input  logic                           sample_ready_i,
    output logic                           sample_last_o
);

    localparam int unsigned N_PTS = 1 << POINT_FFT_POW2;
    localparam int unsigned IW    = POINT_FFT_POW2;

    typedef enum logic {ST_EMPTY, ST_STREAM} state_e;

    state_e                         state_q, state_d;
    logic                           wr_bank_q, wr_bank_d;
    logic                           rd_bank_q, rd_bank_d;
    logic [1:0]                     full_cnt_q, full_cnt_d;
    logic [IW-1:0]                  rd_idx_q, rd_idx_d;
    logic                           frame_ready_q, frame_ready_d;
    logic signed [1:0][FRAC_BITS:0] sample_q, sample_d;
    logic                           last_q, last_d;

    logic                           accept;
    logic                           beat;
    logic                           last_beat;
    logic                           bypass;
    logic [IW-1:0]                  raddr;
    logic [1:0]                     bank_we;
    logic signed [1:0][FRAC_BITS:0] rdata [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .POW2      (POINT_FFT_POW2),
            .FRAC_BITS (FRAC_BITS)
        ) u_bank (
            .clk_i     (clk_i),
            .we_i      (bank_we[b]),
            .wdata_i   (frame_i),
            .raddr_i   (raddr),
            .rdata_c_o (rdata[b])
        );
    end

    // Output registers are loaded from next-state, so the read uses post-edge bank/index.
    // A frame landing in the bank being read this edge is forwarded straight from frame_i.
    always_comb begin
        accept        = frame_valid_i & frame_ready_q;
        beat          = (state_q == ST_STREAM) & sample_ready_i;
        last_beat     = beat & (rd_idx_q == IW'(N_PTS - 1));
        wr_bank_d     = wr_bank_q ^ accept;
        rd_bank_d     = rd_bank_q ^ last_beat;
        rd_idx_d      = beat ? rd_idx_q + IW'(1) : rd_idx_q;
        full_cnt_d    = full_cnt_q + 2'(accept) - 2'(last_beat);
        state_d       = (full_cnt_d != 2'd0) ? ST_STREAM : ST_EMPTY;
        frame_ready_d = (full_cnt_d != 2'd2);
        raddr         = BITREV_EN ? IW'(bitrev(16'(rd_idx_d), POINT_FFT_POW2)) : rd_idx_d;
        bypass        = accept & (wr_bank_q == rd_bank_d);
        bank_we       = {accept & wr_bank_q, accept & ~wr_bank_q};
        sample_d      = '0;
        last_d        = 1'b0;
        if (state_d == ST_STREAM) begin
            sample_d = bypass ? frame_i[raddr] : rdata[rd_bank_d];
            last_d   = (rd_idx_d == IW'(N_PTS - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_EMPTY;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_cnt_q    <= 2'd0;
            rd_idx_q      <= '0;
            frame_ready_q <= 1'b1;
            sample_q      <= '0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            full_cnt_q    <= full_cnt_d;
            rd_idx_q      <= rd_idx_d;
            frame_ready_q <= frame_ready_d;
            sample_q      <= sample_d;
            last_q        <= last_d;
        end
    end

    assign frame_ready_o  = frame_ready_q;
    assign sample_valid_o = (state_q == ST_STREAM);
    assign sample_o       = sample_q;
    assign sample_idx_o   = rd_idx_q;
    assign sample_last_o  = last_q;

endmodule

// File: tb/tb_fft_bitrev_streamer.sv
// Self-checking bench for fft_bitrev_streamer: table-driven streams plus directed
// sequences for back-to-back frames and mid-stream reset.
module tb_fft_bitrev_streamer;
    import fft_pkg::*;

    logic   clk = 1'b0;
    logic   rst_i = 1'b0;
    frame_t frame_i;
    logic   frame_valid_i = 1'b0;
    logic   sample_ready_i = 1'b0;

    logic       frame_ready_o, sample_valid_o, sample_last_o;
    cplx_t      sample_o;
    logic [3:0] sample_idx_o;
    logic       frame_ready_nr, sample_valid_nr, sample_last_nr;
    cplx_t      sample_nr;
    logic [3:0] sample_idx_nr;

    int n_checks = 0;
    int n_err    = 0;
    int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    typedef struct {
        logic        rdy;
        logic        valid;
        int          idx;
        logic [31:0] s;
        logic [31:0] s_nr;
        logic        last;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    fft_bitrev_streamer #(.BITREV_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o), .sample_o(sample_o), .sample_idx_o(sample_idx_o),
        .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
        .sample_last_o(sample_last_o)
    );

    fft_bitrev_streamer #(.BITREV_EN(1'b0)) dut_nr (
        .clk_i(clk), .rst_i(rst_i), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_nr), .sample_o(sample_nr), .sample_idx_o(sample_idx_nr),
        .sample_valid_o(sample_valid_nr), .sample_ready_i(sample_ready_i),
        .sample_last_o(sample_last_nr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame tag t, word j: Re = (j<<8)+t, Im = -j-16t; packed as {Im, Re}.
    function automatic logic [31:0] exp_cplx(input int tag, input int j);
        logic [15:0] re, im;
        re = 16'((j << 8) + tag);
        im = 16'(-j - 16 * tag);
        return {im, re};
    endfunction

    function automatic frame_t mk_frame(input int tag);
        frame_t f;
        for (int j = 0; j < 16; j++) begin
            f[j] = exp_cplx(tag, j);
        end
        return f;
    endfunction

    task automatic fill_table(input int tag, input int ncyc, input bit bp);
        int nb;
        nb = 0;
        tbl.delete();
        for (int c = 0; c < ncyc; c++) begin
            vec_t v;
            v.rdy   = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            v.valid = (nb < 16);
            v.idx   = 0;
            v.s     = '0;
            v.s_nr  = '0;
            v.last  = 1'b0;
            if (nb < 16) begin
                v.idx  = nb;
                v.s    = exp_cplx(tag, br_tab[nb]);
                v.s_nr = exp_cplx(tag, nb);
                v.last = (nb == 15);
                if (v.rdy) nb++;
            end
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input string tn, output int nbeats);
        nbeats = 0;
        foreach (tbl[i]) begin
            sample_ready_i = tbl[i].rdy;
            chk($sformatf("%s_valid[%0d]", tn, i), 64'(sample_valid_o), 64'(tbl[i].valid));
            chk($sformatf("%s_idx[%0d]", tn, i), 64'(sample_idx_o), 64'(tbl[i].idx));
            chk($sformatf("%s_sample[%0d]", tn, i), {32'd0, sample_o}, {32'd0, tbl[i].s});
            chk($sformatf("%s_last[%0d]", tn, i), 64'(sample_last_o), 64'(tbl[i].last));
            chk($sformatf("%s_nr_sample[%0d]", tn, i), {32'd0, sample_nr}, {32'd0, tbl[i].s_nr});
            if (sample_valid_o && sample_ready_i) nbeats++;
            tick();
        end
    endtask

    task automatic send_frame(input int tag);
        frame_i       = mk_frame(tag);
        frame_valid_i = 1'b1;
        chk("send_ready", 64'(frame_ready_o), 64'(1));
        tick();
        frame_valid_i = 1'b0;
    endtask

    initial begin
        int nbeats;
        int na;
        int acc_cyc [3];

        // Test 1: async reset between edges, no clock edge yet
        frame_i = mk_frame(0);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_async_ready", 64'(frame_ready_o), 64'(1));
        chk("rst_async_valid", 64'(sample_valid_o), 64'(0));
        chk("rst_async_sample", {32'd0, sample_o}, 64'(0));
        tick();
        tick();
        chk("rst_idx", 64'(sample_idx_o), 64'(0));
        chk("rst_last", 64'(sample_last_o), 64'(0));
        rst_i = 1'b0;
        tick();
        chk("idle_valid", 64'(sample_valid_o), 64'(0));

        // Test 2/3: single frame, ready high; bit-reversed and plain-order instances
        sample_ready_i = 1'b1;
        send_frame(0);
        fill_table(0, 18, 1'b0);
        run_table("t2", nbeats);
        chk("t2_beats", 64'(nbeats), 64'(16));

        // Test 4: backpressure 1,0,0,1 over 40 cycles
        sample_ready_i = 1'b0;
        send_frame(7);
        fill_table(7, 40, 1'b1);
        run_table("t4", nbeats);
        chk("t4_beats", 64'(nbeats), 64'(16));

        // Test 5: three frames offered back-to-back, ready high
        na = 0;
        acc_cyc = '{-1, -1, -1};
        sample_ready_i = 1'b1;
        for (int c = 0; c < 56; c++) begin
            frame_valid_i = (na < 3);
            frame_i       = mk_frame(na + 1);
            chk($sformatf("t5_ready[%0d]", c), 64'(frame_ready_o),
                64'(!((c >= 2 && c <= 16) || (c >= 18 && c <= 32))));
            chk($sformatf("t5_valid[%0d]", c), 64'(sample_valid_o), 64'(c >= 1 && c <= 48));
            if (c >= 1 && c <= 48) begin
                chk($sformatf("t5_sample[%0d]", c), {32'd0, sample_o},
                    {32'd0, exp_cplx(1 + (c - 1) / 16, br_tab[(c - 1) % 16])});
                chk($sformatf("t5_idx[%0d]", c), 64'(sample_idx_o), 64'((c - 1) % 16));
                chk($sformatf("t5_last[%0d]", c), 64'(sample_last_o), 64'((c - 1) % 16 == 15));
            end
            if (frame_valid_i && frame_ready_o && na < 3) begin
                acc_cyc[na] = c;
                na++;
            end
            tick();
        end
        frame_valid_i = 1'b0;
        chk("t5_acc0", 64'(acc_cyc[0]), 64'(0));
        chk("t5_acc1", 64'(acc_cyc[1]), 64'(1));
        chk("t5_acc2", 64'(acc_cyc[2]), 64'(17));

        // Test 6: reset after 5 beats with a second frame queued
        frame_i       = mk_frame(4);
        frame_valid_i = 1'b1;
        tick();
        frame_i = mk_frame(5);
        tick();
        frame_valid_i = 1'b0;
        repeat (4) tick();
        chk("t6_pre_idx", 64'(sample_idx_o), 64'(5));
        chk("t6_pre_full", 64'(frame_ready_o), 64'(0));
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_ready", 64'(frame_ready_o), 64'(1));
        chk("t6_rst_valid", 64'(sample_valid_o), 64'(0));
        chk("t6_rst_sample", {32'd0, sample_o}, 64'(0));
        chk("t6_rst_idx", 64'(sample_idx_o), 64'(0));
        chk("t6_rst_last", 64'(sample_last_o), 64'(0));
        @(posedge clk);
        #3 rst_i = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t6_stale[%0d]", c), 64'(sample_valid_o), 64'(0));
            tick();
        end
        send_frame(6);
        fill_table(6, 17, 1'b0);
        run_table("t6", nbeats);
        chk("t6_beats", 64'(nbeats), 64'(16));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
